// File: rtl/bp_be_fe_queue_buffer.sv
// rtl/bp_be_fe_queue_buffer.sv - speculative FE queue buffer with read/commit/roll pointers
// Optional same-cycle bypass of an empty queue: BP_FE_QUEUE_BUFFER_BYPASS_EN
package bp_be_fe_queue_buffer_pkg;
    typedef enum logic [1:0] {
        e_bp_inv_cfg     = 2'd0,
        e_bp_default_cfg = 2'd1
    } bp_params_e;

    function automatic int fe_queue_width(input bp_params_e cfg);
        return (cfg == e_bp_default_cfg) ? 48 : 32;
    endfunction
endpackage

module bp_be_fe_queue_buffer
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int els_p = 8,
    localparam int fe_queue_width_lp = fe_queue_width(bp_params_p),
    localparam int ptr_w_lp = $clog2(els_p) + 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,
    output logic [fe_queue_width_lp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_yumi_i,
    input  logic                         commit_i,
    input  logic                         roll_i,
    input  logic                         clr_i,
    output logic [ptr_w_lp-1:0]          count_o
);

    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] cptr_q, cptr_d;
    logic [fe_queue_width_lp-1:0] mem_q [els_p];

    logic [ptr_w_lp-1:0] used;
    logic                enq;
    logic                stored_v;
    logic [fe_queue_width_lp-1:0] stored_data;

    // Fullness is judged against committed space only, so speculative reads never free slots.
    assign used             = wptr_q - cptr_q;
    assign fe_queue_ready_o = ~reset_i & (used < ptr_w_lp'(els_p));
    assign enq              = fe_queue_v_i & fe_queue_ready_o;
    assign count_o          = reset_i ? '0 : used;
    assign stored_v         = (rptr_q != wptr_q);
    assign stored_data      = mem_q[rptr_q[ptr_w_lp-2:0]];

`ifdef BP_FE_QUEUE_BUFFER_BYPASS_EN
    logic bypass;
    assign bypass       = ~stored_v & enq & ~clr_i & ~roll_i;
    assign fe_queue_v_o = ~reset_i & (stored_v | bypass);
    assign fe_queue_o   = bypass ? fe_queue_i : stored_data;
`else
    assign fe_queue_v_o = ~reset_i & stored_v;
    assign fe_queue_o   = stored_data;
`endif

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (clr_i) begin
            // Flush collapses every pointer onto the unadvanced write pointer.
            rptr_d = wptr_q;
            cptr_d = wptr_q;
        end else begin
            wptr_d = wptr_q + ptr_w_lp'(enq);
            cptr_d = cptr_q + ptr_w_lp'(commit_i);
            if (roll_i) begin
                rptr_d = cptr_d;
            end else begin
                rptr_d = rptr_q + ptr_w_lp'(fe_queue_yumi_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq & ~clr_i) begin
            mem_q[wptr_q[ptr_w_lp-2:0]] <= fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_queue_yumi_i |-> fe_queue_v_o);
    commit_without_read: assert property (@(posedge clk_i) disable iff (reset_i)
        commit_i |-> (cptr_q != rptr_q));
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// tb/tb_bp_be_fe_queue_buffer.sv - randomized and directed bench against a queue-based model
module tb_bp_be_fe_queue_buffer;
    import bp_be_fe_queue_buffer_pkg::*;

    localparam int ELS = 8;
    localparam int W   = fe_queue_width(e_bp_inv_cfg);
    localparam int PW  = $clog2(ELS) + 1;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  fe_queue_i = '0;
    logic          fe_queue_v_i = 1'b0;
    logic          fe_queue_ready_o;
    logic [W-1:0]  fe_queue_o;
    logic          fe_queue_v_o;
    logic          fe_queue_yumi_i = 1'b0;
    logic          commit_i = 1'b0;
    logic          roll_i = 1'b0;
    logic          clr_i = 1'b0;
    logic [PW-1:0] count_o;

    bp_be_fe_queue_buffer #(.bp_params_p(e_bp_inv_cfg), .els_p(ELS)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
        .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
        .commit_i(commit_i), .roll_i(roll_i), .clr_i(clr_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: every uncommitted entry in order; rd counts how many of them have been read.
    logic [W-1:0] mq[$];
    int           rd = 0;

    function automatic logic m_ready();
        return mq.size() < ELS;
    endfunction

    function automatic logic m_bypass(input logic vi, input logic k, input logic r);
`ifdef BP_FE_QUEUE_BUFFER_BYPASS_EN
        return (rd == mq.size()) && vi && m_ready() && !k && !r;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_valid(input logic vi, input logic k, input logic r);
        return (rd < mq.size()) || m_bypass(vi, k, r);
    endfunction

    task automatic step(input logic vi, input logic [W-1:0] d, input logic y,
                        input logic c, input logic r, input logic k);
        logic acc;
        @(negedge clk_i);
        fe_queue_v_i = vi; fe_queue_i = d; fe_queue_yumi_i = y;
        commit_i = c; roll_i = r; clr_i = k;
        #1;
        check("ready", 64'(fe_queue_ready_o), 64'(m_ready()));
        check("count", 64'(count_o), 64'(mq.size()));
        check("valid", 64'(fe_queue_v_o), 64'(m_valid(vi, k, r)));
        if (m_valid(vi, k, r))
            check("data", 64'(fe_queue_o), 64'((rd < mq.size()) ? mq[rd] : d));
        @(posedge clk_i);
        acc = vi && m_ready();
        if (k) begin
            mq.delete();
            rd = 0;
        end else begin
            if (acc) mq.push_back(d);
            if (c) begin
                void'(mq.pop_front());
                rd--;
            end
            if (r) rd = 0;
            else if (y) rd++;
        end
    endtask

    task automatic peek();
        @(negedge clk_i);
        fe_queue_v_i = 0; fe_queue_yumi_i = 0; commit_i = 0; roll_i = 0; clr_i = 0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1;
        fe_queue_v_i = 0; fe_queue_yumi_i = 0; commit_i = 0; roll_i = 0; clr_i = 0;
        #1;
        check("rst_ready", 64'(fe_queue_ready_o), 64'd0);
        check("rst_valid", 64'(fe_queue_v_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        @(posedge clk_i);
        mq.delete();
        rd = 0;
        @(negedge clk_i);
        reset_i = 0;
        #1;
        check("post_rst_ready", 64'(fe_queue_ready_o), 64'd1);
        check("post_rst_valid", 64'(fe_queue_v_o), 64'd0);
    endtask

    task automatic enq(input logic [W-1:0] d);
        step(1, d, 0, 0, 0, 0);
    endtask

    task automatic yumi();
        step(0, '0, 1, 0, 0, 0);
    endtask

    task automatic commit();
        step(0, '0, 0, 1, 0, 0);
    endtask

    initial begin
        logic vi, y, c, r, k;

        do_reset();
        // Fill to capacity, then a rejected ninth offer
        for (int i = 0; i < 8; i++) enq(W'(32'hA0 + i));
        peek();
        check("full_ready", 64'(fe_queue_ready_o), 64'd0);
        check("full_count", 64'(count_o), 64'd8);
        enq(W'(32'hA8));
        peek();
        check("full_count_after_9th", 64'(count_o), 64'd8);

        // Read one, commit it, next enqueue wraps into slot 0
        yumi();
        commit();
        peek();
        check("freed_ready", 64'(fe_queue_ready_o), 64'd1);
        enq(W'(32'hA8));
        for (int i = 0; i < 8; i++) yumi();
        peek();
        check("drained_valid", 64'(fe_queue_v_o), 64'd0);

        // Roll back speculative reads
        do_reset();
        for (int i = 0; i < 3; i++) enq(W'(32'hA0 + i));
        yumi();
        yumi();
        step(0, '0, 0, 0, 1, 0);
        peek();
        check("roll_data", 64'(fe_queue_o), 64'hA0);
        check("roll_count", 64'(count_o), 64'd3);

        // Clear with a simultaneous enqueue
        do_reset();
        for (int i = 0; i < 5; i++) enq(W'(32'hC0 + i));
        yumi();
        yumi();
        commit();
        commit();
        step(1, W'(32'hEE), 0, 0, 0, 1);
        peek();
        check("clr_valid", 64'(fe_queue_v_o), 64'd0);
        check("clr_count", 64'(count_o), 64'd0);
        enq(W'(32'hF0));
        peek();
        check("clr_next_data", 64'(fe_queue_o), 64'hF0);

        // Roll and clear together behave as clear
        enq(W'(32'hF1));
        yumi();
        step(0, '0, 0, 1, 1, 1);
        peek();
        check("rollclr_valid", 64'(fe_queue_v_o), 64'd0);
        check("rollclr_count", 64'(count_o), 64'd0);

        // Reset while holding entries
        for (int i = 0; i < 4; i++) enq(W'(32'hD0 + i));
        do_reset();

`ifdef BP_FE_QUEUE_BUFFER_BYPASS_EN
        step(1, W'(32'hB0), 1, 0, 0, 0);
        peek();
        check("bypass_next_valid", 64'(fe_queue_v_o), 64'd0);
        check("bypass_next_count", 64'(count_o), 64'd1);
        do_reset();
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            vi = 1'($urandom_range(0, 1));
            k  = ($urandom_range(0, 31) == 0);
            r  = ($urandom_range(0, 11) == 0);
            c  = (rd > 0) && ($urandom_range(0, 1) == 1);
            y  = m_valid(vi, k, r) && ($urandom_range(0, 2) != 0);
            step(vi, W'($urandom), y, c, r, k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
